fu_alu_seq: RTL and testbench
=============================

# fu_alu_seq

Sequencing front-end for the ALU functional unit. Accepts issued ALU micro-ops through a valid/ready port, registers operands into an execute stage that drives the ALU through its `alu` modport, and queues results and flags for writeback through a second valid/ready port. It sits between the issue/scoreboard logic and the writeback arbiter, and owns all ALU pipeline state and backpressure.

## Interface
Parameters:
- `DEPTH`, 2, writeback queue entries; a power of two, at least 2.

Ports:
- `CLK`  in  1  clock.
- `RST`  in  1  reset; asynchronous assert, active-high.
- `flush`  in  1  synchronous squash of all in-flight ops.
- `issue_valid`  in  1  micro-op offered.
- `issue_ready`  out  1  micro-op accepted when high with `issue_valid`.
- `issue_aluop`  in  4  ALU opcode (`aluop_t`).
- `issue_rs1`  in  32  operand A.
- `issue_rs2`  in  32  operand B register value.
- `issue_imm`  in  32  immediate.
- `issue_use_imm`  in  1  selects `issue_imm` instead of `issue_rs2` for port B.
- `issue_rd`  in  5  destination register.
- `alu`  `fu_alu_if.tb`  —  drives `aluop`, `port_a`, `port_b`; samples `port_output`, `negative`, `overflow`, `zero`.
- `wb_valid`  out  1  result available.
- `wb_ready`  in  1  writeback consumes the result.
- `wb_data`  out  32  result.
- `wb_rd`  out  5  destination register.
- `wb_flags`  out  3  {negative, overflow, zero}.
- `perf_issued`, `perf_stall`  out  32 each  present only under `FU_ALU_PERF_EN`.

## Operation
- Issue fire: `issue_valid && issue_ready`. On fire, the EX register loads aluop, A, muxed B and rd, and sets `ex_valid`.
- EX stage: the EX register drives the ALU combinationally. Each cycle `ex_valid` is high, the EX stage pushes {port_output, rd, flags} into the writeback queue.
- EX advances to empty unless a new issue fires in the same cycle. Back-to-back issue gives one result per cycle.
- `issue_ready = (count + ex_valid - wb_fire) < DEPTH`, where `wb_fire = wb_valid && wb_ready`.
  - This is combinational from `wb_ready`, which is intentional.
  - It guarantees a queue push never meets a full queue.
- Writeback: `wb_valid = (count != 0)`. The head entry drives `wb_data`, `wb_rd` and `wb_flags`, and pops on `wb_fire`. Results leave in issue order.
- Simultaneous push and pop on the same edge: count is unchanged. Pointers wrap modulo `DEPTH`.
- `flush`: on the next edge, clear `ex_valid`, `count` and both pointers.
  - An issue that fires in the flush cycle is dropped.
  - A `wb_fire` in the flush cycle still counts as delivered.
  - `flush` has priority over push and pop.
- The ALU inputs hold their last value when `ex_valid` is low. Only `ex_valid` gates the push.
- Unknown opcodes pass through to the ALU unchanged.

## Timing
- Reset values:
  - `ex_valid` = 0, count = 0, pointers = 0.
  - `wb_valid` = 0; `wb_data`, `wb_rd`, `wb_flags` = 0.
  - `issue_ready` = 1 after reset.
  - ALU drive registers = 0.
  - Perf counters = 0.
- Latency: issue fires at edge N → the ALU evaluates in cycle N+1 → `wb_valid` is high from cycle N+2. Minimum 2 cycles.
- Sustained throughput is 1 op/cycle while `wb_ready` stays high.
- Reset asserted mid-operation discards every in-flight op immediately; there is no partial output.

## Configuration
- `FU_ALU_PERF_EN` defined:
  - `perf_issued` increments on each issue fire.
  - `perf_stall` increments on each cycle with `issue_valid && !issue_ready`.
  - Both are 32-bit, wrap silently, reset to 0, and are not cleared by `flush`.
- Undefined: the counter ports and logic are absent; all other behaviour is identical.

## Structure
- `isa_pkg`: `aluop_t` and the opcode constants.
- `datapath_pkg`: `word_t`, and `alu_wb_t` struct {`word_t data`; `logic [4:0] rd`; `logic [2:0] flags`}.
- Sub-module `fu_alu_wbq`: a parameterized synchronous FIFO of `alu_wb_t` with push, pop, flush, count and head outputs. `fu_alu_seq` holds the EX register, the ready logic and the counters.

## Test plan
- Single ADD: rs1=5, rs2=7 issued at cycle 0 → `wb_valid` at cycle 2 with `wb_data`=12, `wb_rd` as issued, flags=000.
- Immediate SUB: rs1=3, imm=3, use_imm=1 → `wb_data`=0, flags zero=1; then rs1=0, imm=1 → 0xFFFFFFFF, negative=1.
- Overflow: ADD 0x7FFFFFFF + 1 → `wb_data`=0x80000000, flags=110.
- Backpressure: 4 back-to-back issues with `wb_ready`=0 → `issue_ready` drops after 2 accepted. Release `wb_ready` → all 4 results in order, no loss or duplication.
- Flush: issue 2 ops, assert `flush` in the cycle of the second `wb_valid` with `wb_ready`=0 → no `wb_valid` afterwards and `issue_ready`=1. A following op completes normally.
- Perf build: 10 issues with 3 stall cycles → `perf_issued`=10, `perf_stall`=3. Both read 0 after `RST`.

Source files
------------

// File: rtl/datapath_pkg.sv
// Datapath word type and the writeback record carried from the ALU to the writeback arbiter.
package datapath_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t       data;
        logic [4:0]  rd;
        logic [2:0]  flags;
    } alu_wb_t;

    // Flag vector layout is {negative, overflow, zero}.
    function automatic logic [2:0] pack_flags(input logic negative, input logic overflow,
                                              input logic zero);
        return {negative, overflow, zero};
    endfunction

endpackage

// File: rtl/isa_pkg.sv
// ALU instruction-set definitions shared by the issue logic and the ALU functional unit.
package isa_pkg;

    // Opcodes outside this list are legal to issue; they reach the ALU unchanged.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

endpackage

// File: rtl/fu_alu_if.sv
// Connection between the ALU sequencer and the combinational ALU.
// Modport tb: the sequencer side driving operands; modport alu: the ALU side.
interface fu_alu_if;
    import isa_pkg::*;
    import datapath_pkg::*;

    aluop_t aluop;
    word_t  port_a;
    word_t  port_b;
    word_t  port_output;
    logic   negative;
    logic   overflow;
    logic   zero;

    modport tb (
        output aluop, port_a, port_b,
        input  port_output, negative, overflow, zero
    );

    modport alu (
        input  aluop, port_a, port_b,
        output port_output, negative, overflow, zero
    );

endinterface

// File: rtl/fu_alu_wbq.sv
// Writeback queue of ALU results: a small synchronous FIFO with flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module fu_alu_wbq
    import datapath_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      push,
    input  alu_wb_t                   push_data,
    input  logic                      pop,
    output logic [$clog2(DEPTH):0]    count,
    output alu_wb_t                   head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;

    alu_wb_t        mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    assign head = mem[rd_ptr];

    // Storage, pointers and occupancy; flush wins over a simultaneous push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

endmodule

// File: rtl/fu_alu_seq.sv
// ALU sequencing front-end: issue port -> EX register driving the ALU -> writeback queue.
// Optional build macro FU_ALU_PERF_EN adds issue and stall performance counters.
module fu_alu_seq
    import isa_pkg::*;
    import datapath_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         flush,
    input  logic         issue_valid,
    output logic         issue_ready,
    input  aluop_t       issue_aluop,
    input  word_t        issue_rs1,
    input  word_t        issue_rs2,
    input  word_t        issue_imm,
    input  logic         issue_use_imm,
    input  logic [4:0]   issue_rd,
    fu_alu_if.tb         alu,
`ifdef FU_ALU_PERF_EN
    output logic [31:0]  perf_issued,
    output logic [31:0]  perf_stall,
`endif
    output logic         wb_valid,
    input  logic         wb_ready,
    output word_t        wb_data,
    output logic [4:0]   wb_rd,
    output logic [2:0]   wb_flags
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW+1:0] DEPTH_W = (AW + 2)'(DEPTH);

    logic          ex_valid;
    aluop_t        ex_aluop;
    word_t         ex_a;
    word_t         ex_b;
    logic [4:0]    ex_rd;

    logic          issue_fire;
    logic          wb_fire;
    logic [AW:0]   q_count;
    logic [AW+1:0] occupancy;
    alu_wb_t       push_data;
    alu_wb_t       q_head;

    // Occupancy counts the op in EX as already queued, so a push never finds the queue full.
    assign wb_fire     = wb_valid && wb_ready;
    assign occupancy   = {1'b0, q_count} + {{(AW + 1){1'b0}}, ex_valid}
                       - {{(AW + 1){1'b0}}, wb_fire};
    assign issue_ready = occupancy < DEPTH_W;
    assign issue_fire  = issue_valid && issue_ready;

    assign alu.aluop  = ex_aluop;
    assign alu.port_a = ex_a;
    assign alu.port_b = ex_b;

    // EX register: loads on issue, empties otherwise; ALU operands hold their last value when idle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ex_valid <= 1'b0;
            ex_aluop <= aluop_t'(4'd0);
            ex_a     <= '0;
            ex_b     <= '0;
            ex_rd    <= '0;
        end else begin
            ex_valid <= issue_fire && !flush;
            if (issue_fire && !flush) begin
                ex_aluop <= issue_aluop;
                ex_a     <= issue_rs1;
                ex_b     <= issue_use_imm ? issue_imm : issue_rs2;
                ex_rd    <= issue_rd;
            end
        end
    end

    assign push_data = '{data:  alu.port_output,
                         rd:    ex_rd,
                         flags: pack_flags(alu.negative, alu.overflow, alu.zero)};

    fu_alu_wbq #(.DEPTH(DEPTH)) u_wbq (
        .clk       (CLK),
        .rst       (RST),
        .flush     (flush),
        .push      (ex_valid),
        .push_data (push_data),
        .pop       (wb_fire),
        .count     (q_count),
        .head      (q_head)
    );

    assign wb_valid = (q_count != '0);
    assign wb_data  = q_head.data;
    assign wb_rd    = q_head.rd;
    assign wb_flags = q_head.flags;

`ifdef FU_ALU_PERF_EN
    // Performance counters survive flush and wrap silently.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (issue_fire) begin
                perf_issued <= perf_issued + 32'd1;
            end
            if (issue_valid && !issue_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fu_alu_seq.sv
// Scoreboard bench for fu_alu_seq with a behavioural ALU attached to the alu interface.
// Define FU_ALU_PERF_EN to also exercise the performance counters.
module tb_fu_alu_seq;
    import isa_pkg::*;
    import datapath_pkg::*;

    localparam int DEPTH = 2;

    logic         CLK = 1'b0;
    logic         RST;
    logic         flush;
    logic         issue_valid;
    logic         issue_ready;
    aluop_t       issue_aluop;
    word_t        issue_rs1;
    word_t        issue_rs2;
    word_t        issue_imm;
    logic         issue_use_imm;
    logic [4:0]   issue_rd;
    logic         wb_valid;
    logic         wb_ready;
    word_t        wb_data;
    logic [4:0]   wb_rd;
    logic [2:0]   wb_flags;
`ifdef FU_ALU_PERF_EN
    logic [31:0]  perf_issued;
    logic [31:0]  perf_stall;
`endif

    int           checks = 0;
    int           errors = 0;
    alu_wb_t      expQ [$];
    alu_wb_t      monExp;
    word_t        aluRes;
    logic         aluOvf;

    fu_alu_if aluif ();

    fu_alu_seq #(.DEPTH(DEPTH)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .flush         (flush),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_aluop   (issue_aluop),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_imm     (issue_imm),
        .issue_use_imm (issue_use_imm),
        .issue_rd      (issue_rd),
        .alu           (aluif),
`ifdef FU_ALU_PERF_EN
        .perf_issued   (perf_issued),
        .perf_stall    (perf_stall),
`endif
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_data       (wb_data),
        .wb_rd         (wb_rd),
        .wb_flags      (wb_flags)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 CLK = ~CLK;

    // Behavioural ALU; unknown opcodes produce a fixed marker so pass-through is visible.
    always_comb begin
        aluRes = '0;
        aluOvf = 1'b0;
        case (aluif.aluop)
            ALU_ADD: begin
                aluRes = aluif.port_a + aluif.port_b;
                aluOvf = (aluif.port_a[31] == aluif.port_b[31]) && (aluRes[31] != aluif.port_a[31]);
            end
            ALU_SUB: begin
                aluRes = aluif.port_a - aluif.port_b;
                aluOvf = (aluif.port_a[31] != aluif.port_b[31]) && (aluRes[31] != aluif.port_a[31]);
            end
            ALU_AND: aluRes = aluif.port_a & aluif.port_b;
            ALU_OR:  aluRes = aluif.port_a | aluif.port_b;
            ALU_XOR: aluRes = aluif.port_a ^ aluif.port_b;
            default: aluRes = 32'hDEAD_BEEF;
        endcase
        aluif.port_output = aluRes;
        aluif.negative    = aluRes[31];
        aluif.overflow    = aluOvf;
        aluif.zero        = (aluRes == '0);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, actual, required, $time);
        end
    endtask

    // Monitor: every delivered writeback is compared against the oldest expected result.
    always @(negedge CLK) begin
        if (!RST && wb_valid && wb_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_wb: actual data=%h rd=%0d, required no output",
                         wb_data, wb_rd);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("wb_data", wb_data, monExp.data);
                checkOutput("wb_rd", 32'(wb_rd), 32'(monExp.rd));
                checkOutput("wb_flags", 32'(wb_flags), 32'(monExp.flags));
            end
        end
    end

    // Offer one op (called just after a rising edge); returns just after the edge it fires on.
    task automatic applyStimulus(input aluop_t op, input word_t rs1, input word_t rs2,
                                 input word_t imm, input logic useImm, input logic [4:0] rd,
                                 input word_t expData, input logic [2:0] expFlags);
        int waitCycles;
        issue_aluop   = op;
        issue_rs1     = rs1;
        issue_rs2     = rs2;
        issue_imm     = imm;
        issue_use_imm = useImm;
        issue_rd      = rd;
        issue_valid   = 1'b1;
        waitCycles    = 0;
        @(negedge CLK);
        while (!issue_ready && waitCycles < 50) begin
            waitCycles++;
            @(negedge CLK);
        end
        if (!issue_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL issue_timeout: actual issue_ready=0 for 50 cycles, required 1 (rd=%0d)", rd);
            @(posedge CLK);
            #1;
            issue_valid = 1'b0;
        end else begin
            @(posedge CLK);
            #1;
            expQ.push_back('{data: expData, rd: rd, flags: expFlags});
            issue_valid = 1'b0;
        end
    endtask

    task automatic waitDrain();
        int cyc;
        cyc = 0;
        while (expQ.size() != 0 && cyc < 100) begin
            @(posedge CLK);
            cyc++;
        end
        checkOutput("drain_remaining", 32'(expQ.size()), 32'd0);
        @(posedge CLK);
        #1;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        RST           = 1'b1;
        flush         = 1'b0;
        issue_valid   = 1'b0;
        issue_aluop   = ALU_ADD;
        issue_rs1     = '0;
        issue_rs2     = '0;
        issue_imm     = '0;
        issue_use_imm = 1'b0;
        issue_rd      = '0;
        wb_ready      = 1'b0;

        @(negedge CLK);
        checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("rst_issue_ready", 32'(issue_ready), 32'd1);
        checkOutput("rst_wb_data", wb_data, 32'd0);
        checkOutput("rst_wb_rd", 32'(wb_rd), 32'd0);
        checkOutput("rst_wb_flags", 32'(wb_flags), 32'd0);
        checkOutput("rst_port_a", aluif.port_a, 32'd0);
        checkOutput("rst_port_b", aluif.port_b, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        wb_ready = 1'b1;

        // Single ADD with latency check: invisible one cycle after fire, visible the next.
        applyStimulus(ALU_ADD, 32'd5, 32'd7, 32'd0, 1'b0, 5'd3, 32'd12, 3'b000);
        @(negedge CLK);
        checkOutput("latency_cycle1_wb_valid", 32'(wb_valid), 32'd0);
        @(negedge CLK);
        checkOutput("latency_cycle2_wb_valid", 32'(wb_valid), 32'd1);
        @(posedge CLK);
        #1;

        // Back-to-back: immediate SUBs, signed overflow, unknown opcode pass-through.
        applyStimulus(ALU_SUB, 32'd3, 32'd99, 32'd3, 1'b1, 5'd4, 32'd0, 3'b001);
        applyStimulus(ALU_SUB, 32'd0, 32'd99, 32'd1, 1'b1, 5'd5, 32'hFFFF_FFFF, 3'b100);
        applyStimulus(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd6, 32'h8000_0000, 3'b110);
        applyStimulus(aluop_t'(4'hF), 32'd1, 32'd2, 32'd0, 1'b0, 5'd31, 32'hDEAD_BEEF, 3'b100);
        waitDrain();

        // Backpressure: only two ops fit while writeback is stalled.
        wb_ready = 1'b0;
        applyStimulus(ALU_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 5'd7, 32'd2, 3'b000);
        applyStimulus(ALU_ADD, 32'd2, 32'd2, 32'd0, 1'b0, 5'd8, 32'd4, 3'b000);
        issue_aluop = ALU_AND;
        issue_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checkOutput("bp_issue_ready", 32'(issue_ready), 32'd0);
        end
        checkOutput("bp_wb_valid", 32'(wb_valid), 32'd1);
        @(posedge CLK);
        #1;
        wb_ready = 1'b1;
        applyStimulus(ALU_AND, 32'h0000_00F0, 32'h0000_003C, 32'd0, 1'b0, 5'd9, 32'h0000_0030, 3'b000);
        applyStimulus(ALU_OR, 32'h0000_00F0, 32'h0000_000F, 32'd0, 1'b0, 5'd10, 32'h0000_00FF, 3'b000);
        waitDrain();

        // Flush with two results held in the queue.
        wb_ready = 1'b0;
        applyStimulus(ALU_ADD, 32'd10, 32'd10, 32'd0, 1'b0, 5'd11, 32'd20, 3'b000);
        applyStimulus(ALU_ADD, 32'd20, 32'd20, 32'd0, 1'b0, 5'd12, 32'd40, 3'b000);
        @(posedge CLK);
        #1;
        flush = 1'b1;
        expQ.delete();
        @(posedge CLK);
        #1;
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checkOutput("flush_wb_valid", 32'(wb_valid), 32'd0);
            checkOutput("flush_issue_ready", 32'(issue_ready), 32'd1);
        end
        @(posedge CLK);
        #1;
        wb_ready = 1'b1;
        applyStimulus(ALU_ADD, 32'd100, 32'd200, 32'd0, 1'b0, 5'd13, 32'd300, 3'b000);
        waitDrain();

        // Asynchronous reset in the middle of a cycle discards in-flight ops at once.
        wb_ready = 1'b0;
        applyStimulus(ALU_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 5'd14, 32'd3, 3'b000);
        applyStimulus(ALU_ADD, 32'd3, 32'd4, 32'd0, 1'b0, 5'd15, 32'd7, 3'b000);
        #2;
        RST = 1'b1;
        expQ.delete();
        #1;
        checkOutput("async_rst_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("async_rst_issue_ready", 32'(issue_ready), 32'd1);
        checkOutput("async_rst_port_a", aluif.port_a, 32'd0);
`ifdef FU_ALU_PERF_EN
        checkOutput("perf_issued_after_rst", perf_issued, 32'd0);
        checkOutput("perf_stall_after_rst", perf_stall, 32'd0);
`endif
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        wb_ready = 1'b1;

`ifdef FU_ALU_PERF_EN
        // Ten issues, exactly three stalled cycles.
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(ALU_ADD, 32'(i), 32'(i), 32'd0, 1'b0, 5'(i), 32'(2 * i), 3'b000);
        end
        waitDrain();
        wb_ready = 1'b0;
        applyStimulus(ALU_ADD, 32'd9, 32'd9, 32'd0, 1'b0, 5'd9, 32'd18, 3'b000);
        applyStimulus(ALU_ADD, 32'd10, 32'd10, 32'd0, 1'b0, 5'd10, 32'd20, 3'b000);
        issue_valid = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        issue_valid = 1'b0;
        wb_ready = 1'b1;
        waitDrain();
        checkOutput("perf_issued", perf_issued, 32'd10);
        checkOutput("perf_stall", perf_stall, 32'd3);
`endif

        // Normal operation after reset.
        applyStimulus(ALU_XOR, 32'h0000_00FF, 32'h0000_000F, 32'd0, 1'b0, 5'd16, 32'h0000_00F0, 3'b000);
        waitDrain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
